// File: rtl/cpu_pkg.sv
// Shared CPU definitions: sequencer states, opcode fields, condition codes,
// PC command encoding and PSR flag positions.
package cpu_pkg;

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_UPDATE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    K_ALU    = 2'd0,
    K_BRANCH = 2'd1,
    K_JUMP   = 2'd2
  } instr_kind_t;

  localparam logic [3:0] OP_BCOND  = 4'b1100;
  localparam logic [3:0] OP_JCOND  = 4'b0100;
  localparam logic [3:0] EXT_JCOND = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_HI = 4'b0100;
  localparam logic [3:0] COND_LS = 4'b0101;
  localparam logic [3:0] COND_GT = 4'b0110;
  localparam logic [3:0] COND_LE = 4'b0111;
  localparam logic [3:0] COND_FS = 4'b1000;
  localparam logic [3:0] COND_FC = 4'b1001;
  localparam logic [3:0] COND_LO = 4'b1010;
  localparam logic [3:0] COND_HS = 4'b1011;
  localparam logic [3:0] COND_LT = 4'b1100;
  localparam logic [3:0] COND_GE = 4'b1101;
  localparam logic [3:0] COND_UC = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam logic [1:0] PC_HOLD   = 2'b00;
  localparam logic [1:0] PC_INC    = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_BRANCH = 2'b11;

  // flags bus is {F,L,N,C,Z}
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_L = 3;
  localparam int FLAG_F = 4;

  function automatic instr_kind_t classify(input logic [3:0] opcode,
                                           input logic [3:0] ext);
    if (opcode == OP_BCOND)                     return K_BRANCH;
    else if (opcode == OP_JCOND && ext == EXT_JCOND) return K_JUMP;
    else                                        return K_ALU;
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Condition-code evaluator: decides whether a conditional branch/jump is taken
// from the 4-bit condition field and the PSR flags.
module cond_eval
  import cpu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [4:0] flags,
  output logic       taken
);

  logic z, c, n, l, f;

  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign n = flags[FLAG_N];
  assign l = flags[FLAG_L];
  assign f = flags[FLAG_F];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_EQ: taken = z;
      COND_NE: taken = !z;
      COND_CS: taken = c;
      COND_CC: taken = !c;
      COND_HI: taken = l;
      COND_LS: taken = !l;
      COND_GT: taken = n;
      COND_LE: taken = !n;
      COND_FS: taken = f;
      COND_FC: taken = !f;
      COND_LO: taken = !l && !z;
      COND_HS: taken = l || z;
      COND_LT: taken = !n && !z;
      COND_GE: taken = n || z;
      COND_UC: taken = 1'b1;
      COND_NV: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_control.sv
// Instruction sequencer in front of the PC register: fetch into IR, resolve
// branches/jumps or hand off to the datapath, then issue one PC command.
module fetch_control
  import cpu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pc,
  output logic             mem_rd_en,
  output logic [WIDTH-1:0] mem_addr,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_valid,
  output logic [WIDTH-1:0] ir,
  output logic             exec_start,
  input  logic             exec_done,
  input  logic [4:0]       flags,
  output logic [3:0]       rtarget_sel,
  input  logic [WIDTH-1:0] rtarget_data,
  output logic [1:0]       pc_en,
  output logic [WIDTH-1:0] pc_new_adr,
  output logic [WIDTH-1:0] pc_imm
);

  state_t      state, state_d;
  instr_kind_t kind_q, dec_kind;
  logic        taken_q;
  logic        exec_first_q;
  logic        cond_taken;

  assign dec_kind    = classify(ir[WIDTH-1 -: 4], ir[7:4]);
  assign rtarget_sel = ir[3:0];

  cond_eval u_cond_eval (
    .cond  (ir[11:8]),
    .flags (flags),
    .taken (cond_taken)
  );

  always_comb begin
    state_d    = state;
    mem_rd_en  = 1'b0;
    exec_start = 1'b0;
    pc_en      = PC_HOLD;
    case (state)
      S_FETCH: begin
        // State already sits in FETCH while reset is held; gating keeps the
        // read request low for the whole reset window.
        mem_rd_en = reset;
        if (mem_valid) state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = (dec_kind == K_ALU) ? S_EXEC : S_UPDATE;
      end
      S_EXEC: begin
        exec_start = exec_first_q;
        if (exec_done) state_d = S_UPDATE;
      end
      S_UPDATE: begin
        pc_en = PC_INC;
        if (taken_q) pc_en = (kind_q == K_BRANCH) ? PC_BRANCH : PC_JUMP;
        state_d = S_FETCH;
      end
    endcase
  end

  assign mem_addr = mem_rd_en ? pc : '0;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_FETCH;
      ir           <= '0;
      pc_new_adr   <= '0;
      pc_imm       <= '0;
      kind_q       <= K_ALU;
      taken_q      <= 1'b0;
      exec_first_q <= 1'b0;
    end else begin
      state        <= state_d;
      exec_first_q <= (state == S_DECODE);
      if (state == S_FETCH && mem_valid) ir <= mem_rdata;
      if (state == S_DECODE) begin
        kind_q  <= dec_kind;
        // Flags are only meaningful here: they belong to the previous instruction.
        taken_q <= (dec_kind != K_ALU) && cond_taken;
        if (dec_kind == K_BRANCH) pc_imm <= {{(WIDTH-8){ir[7]}}, ir[7:0]};
        if (dec_kind == K_JUMP)   pc_new_adr <= rtarget_data;
      end
    end
  end

endmodule

// File: tb/tb_fetch_control.sv
// Scoreboard bench for fetch_control: the driver plays memory, datapath and
// register file and queues the expected PC command; a monitor checks it.
module tb_fetch_control;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] pc = 16'h0000;
  logic [15:0] mem_rdata = 16'h0000;
  logic        mem_valid = 1'b0;
  logic        exec_done = 1'b0;
  logic [4:0]  flags = 5'b0;
  logic [15:0] rf [16];
  logic [15:0] rtarget_data;

  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic [15:0] ir;
  logic        exec_start;
  logic [3:0]  rtarget_sel;
  logic [1:0]  pc_en;
  logic [15:0] pc_new_adr;
  logic [15:0] pc_imm;

  fetch_control #(.WIDTH(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .pc           (pc),
    .mem_rd_en    (mem_rd_en),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .mem_valid    (mem_valid),
    .ir           (ir),
    .exec_start   (exec_start),
    .exec_done    (exec_done),
    .flags        (flags),
    .rtarget_sel  (rtarget_sel),
    .rtarget_data (rtarget_data),
    .pc_en        (pc_en),
    .pc_new_adr   (pc_new_adr),
    .pc_imm       (pc_imm)
  );

  always #5 clk = ~clk;

  assign rtarget_data = rf[rtarget_sel];

  typedef struct {
    logic [15:0] ir;
    logic [1:0]  pc_en;
    int          kind;     // 0 datapath, 1 branch, 2 jump
    logic [15:0] opnd;     // pc_imm for branches, pc_new_adr for jumps
    int          n_exec;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   retired = 0;
  int   exec_cnt = 0;
  bit   sb_on = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Reference model: instruction class and condition table.
  function automatic int kind_of(input logic [15:0] instr);
    if (instr[15:12] == 4'hC) return 1;
    if (instr[15:12] == 4'h4 && instr[7:4] == 4'hC) return 2;
    return 0;
  endfunction

  // Codes come in pairs (base, complement); 1110/1111 is always/never.
  function automatic logic cond_ref(input logic [3:0] code, input logic [4:0] f);
    logic fz, fc, fn, fl, ff, base;
    {ff, fl, fn, fc, fz} = f;
    case (code[3:1])
      3'd0: base = fz;
      3'd1: base = fc;
      3'd2: base = fl;
      3'd3: base = fn;
      3'd4: base = ff;
      3'd5: base = !fl && !fz;
      3'd6: base = !fn && !fz;
      default: base = 1'b1;
    endcase
    return base ^ code[0];
  endfunction

  function automatic exp_t model(input logic [15:0] instr, input logic [4:0] f);
    exp_t e;
    logic t;
    e.ir     = instr;
    e.kind   = kind_of(instr);
    t        = cond_ref(instr[11:8], f);
    e.n_exec = (e.kind == 0) ? 1 : 0;
    e.opnd   = 16'h0;
    case (e.kind)
      1: begin
        e.pc_en = t ? 2'b11 : 2'b01;
        e.opnd  = 16'($signed(instr[7:0]));
      end
      2: begin
        e.pc_en = t ? 2'b10 : 2'b01;
        e.opnd  = rf[instr[3:0]];
      end
      default: e.pc_en = 2'b01;
    endcase
    return e;
  endfunction

  // Monitor: checks each PC command against the queue and plays the PC register.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      exec_cnt = 0;
    end else begin
      if (exec_start) exec_cnt++;
      check("mem_addr", mem_addr, mem_rd_en ? pc : 16'h0);
      if (pc_en != 2'b00) begin
        if (sb_on) begin
          if (exp_q.size() == 0) begin
            check("unexpected_pc_en", pc_en, 2'b00);
          end else begin
            e = exp_q.pop_front();
            check("ir", ir, e.ir);
            check("pc_en", pc_en, e.pc_en);
            check("exec_starts", exec_cnt, e.n_exec);
            if (e.kind == 1) check("pc_imm", pc_imm, e.opnd);
            if (e.kind == 2) check("pc_new_adr", pc_new_adr, e.opnd);
          end
        end
        case (pc_en)
          2'b01:   pc = pc + 16'd1;
          2'b10:   pc = pc_new_adr;
          default: pc = pc + pc_imm;
        endcase
        retired++;
        exec_cnt = 0;
      end
    end
  end

  task automatic wait_fetch();
    int n = 0;
    while (!mem_rd_en && n < 20) begin
      step();
      n++;
    end
  endtask

  task automatic run_instr(input logic [15:0] instr, input logic [4:0] f,
                           input int mlat, input int xlat);
    exp_t e;
    int   cnt;
    int   n;
    int   target;
    flags  = f;
    e      = model(instr, f);
    exp_q.push_back(e);
    target = retired + 1;
    wait_fetch();
    check("fetch_request", mem_rd_en, 1'b1);
    if (!mem_rd_en) begin
      exp_q.delete();
      return;
    end
    cnt = 1;
    mem_rdata = 16'($urandom);
    repeat (mlat) begin
      step();
      if (mem_rd_en) cnt++;
    end
    mem_rdata = instr;
    mem_valid = 1'b1;
    step();
    mem_valid = 1'b0;
    mem_rdata = 16'($urandom);
    check("fetch_cycles", cnt, mlat + 1);
    check("rd_en_after_fetch", mem_rd_en, 1'b0);
    step();
    flags = 5'($urandom);
    if (e.kind == 0) begin
      n = 0;
      while (!exec_start && n < 20) begin
        step();
        n++;
      end
      check("exec_start_seen", exec_start, 1'b1);
      repeat (xlat) step();
      exec_done = 1'b1;
      step();
      exec_done = 1'b0;
    end
    n = 0;
    while (retired < target && n < 40) begin
      step();
      n++;
    end
    check("retired", retired, target);
    if (retired < target) exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_rd_en"}, mem_rd_en, 1'b0);
    check({tag, "_mem_addr"}, mem_addr, 16'h0);
    check({tag, "_exec_start"}, exec_start, 1'b0);
    check({tag, "_pc_en"}, pc_en, 2'b00);
    check({tag, "_ir"}, ir, 16'h0);
    check({tag, "_pc_imm"}, pc_imm, 16'h0);
    check({tag, "_pc_new_adr"}, pc_new_adr, 16'h0);
  endtask

  task automatic tied_phase(input logic [15:0] instr, input int gap, input logic [1:0] exp_en);
    int last = -1;
    int pulses = 0;
    sb_on = 1'b0;
    wait_fetch();
    mem_rdata = instr;
    mem_valid = 1'b1;
    exec_done = 1'b1;
    for (int i = 0; i < 24; i++) begin
      step();
      if (pc_en != 2'b00) begin
        check("tied_pc_en", pc_en, exp_en);
        if (last >= 0) check("tied_period", i - last, gap);
        last = i;
        pulses++;
      end
    end
    check("tied_pulses", pulses, 24 / gap);
    mem_valid = 1'b0;
    repeat (4) step();
    exec_done = 1'b0;
    sb_on = 1'b1;
  endtask

  initial begin
    logic [15:0] instr;
    int k;
    for (int i = 0; i < 16; i++) rf[i] = 16'($urandom);

    #1 reset = 1'b0;
    #2 check_reset_outputs("reset");
    step();
    step();
    reset = 1'b1;
    step();
    check("fetch_after_reset", mem_rd_en, 1'b1);

    // ALU op with a 2-cycle memory wait and a slow datapath
    run_instr(16'h0321, 5'b00000, 2, 3);

    // BEQ -2 from 0x0010, taken then not taken
    pc = 16'h0010;
    run_instr(16'hC0FE, 5'b00001, 0, 0);
    pc = 16'h0010;
    run_instr(16'hC0FE, 5'b00000, 0, 0);

    // JUC r5 and the never-taken code
    rf[5] = 16'h1234;
    run_instr(16'h4EC5, 5'($urandom), 0, 0);
    run_instr(16'h4FC5, 5'($urandom), 1, 0);

    // Every condition code against every flag combination
    for (int c = 0; c < 16; c++)
      for (int f = 0; f < 32; f++)
        run_instr({4'hC, 4'(c), 8'($urandom)}, 5'(f), 0, 0);

    // Asynchronous reset while executing; stale pulses must not retire anything
    wait_fetch();
    mem_rdata = 16'h0321;
    mem_valid = 1'b1;
    step();
    mem_valid = 1'b0;
    step();
    check("exec_start_before_reset", exec_start, 1'b1);
    #2 reset = 1'b0;
    #1 check_reset_outputs("reset_exec");
    mem_valid = 1'b1;
    exec_done = 1'b1;
    step();
    mem_valid = 1'b0;
    exec_done = 1'b0;
    step();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exec_done = (i == 1);
      step();
      check("post_reset_pc_en", pc_en, 2'b00);
      check("post_reset_fetch", mem_rd_en, 1'b1);
    end
    exec_done = 1'b0;
    run_instr(16'h1234, 5'($urandom), 1, 1);

    // Asynchronous reset while waiting on memory
    wait_fetch();
    step();
    step();
    #2 reset = 1'b0;
    #1 check("reset_fetch_mem_rd_en", mem_rd_en, 1'b0);
    check("reset_fetch_mem_addr", mem_addr, 16'h0);
    check("reset_fetch_ir", ir, 16'h0);
    step();
    reset = 1'b1;
    step();
    check("refetch_after_reset", mem_rd_en, 1'b1);
    run_instr(16'hC6F0, 5'b00100, 0, 0);

    // Zero-latency memory and datapath
    tied_phase(16'h0321, 4, 2'b01);
    tied_phase(16'hCE05, 3, 2'b11);

    // Randomised mix
    for (int i = 0; i < 300; i++) begin
      if (i % 16 == 0) for (int r = 0; r < 16; r++) rf[r] = 16'($urandom);
      k = $urandom_range(0, 2);
      instr = 16'($urandom);
      if (k == 1) instr[15:12] = 4'hC;
      else if (k == 2) begin
        instr[15:12] = 4'h4;
        instr[7:4] = 4'hC;
      end else begin
        while (kind_of(instr) != 0) instr = 16'($urandom);
      end
      run_instr(instr, 5'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
